// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl
// Owns the divisor feeding the UART baud generator (tick = 16x oversample,
// dvsr = f_clk/(16*baud) - 1). The divisor is loaded either by a direct
// software write or by timing the start bit of an incoming 0x55 sync
// character. Every divisor change is committed on a baud tick so the
// generator never sees a change in the middle of a period.
//
// Optional feature, macro AUTOBAUD_TWO_BIT_EN: measure the start bit plus
// bit0 (low then high) and divide by 32, halving the quantisation error.
// With the macro undefined only the start bit is measured.

module uart_autobaud_ctrl #(
  parameter int unsigned             DVSR_W       = 11,
  parameter int unsigned             CNT_W        = 16,
  parameter logic [DVSR_W-1:0]       DEFAULT_DVSR = 11'd17,
  parameter logic [CNT_W-1:0]        MIN_CNT      = 16'd32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              rx_i,
  input  logic              tick_i,
  input  logic              wr_en_i,
  input  logic [DVSR_W-1:0] wr_dvsr_i,
  input  logic              start_i,
  output logic [DVSR_W-1:0] dvsr_o,
  output logic              busy_o,
  output logic              locked_o,
  output logic              err_o,
  output logic              done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_WAIT_FALL,
    S_MEASURE,
    S_CALC,
    S_APPLY
  } state_e;

  // Rounding term, divide shift and glitch threshold depend on how many
  // bit periods one measurement spans.
`ifdef AUTOBAUD_TWO_BIT_EN
  localparam int unsigned      RND_ADD  = 16;
  localparam int unsigned      SHIFT    = 5;
  localparam logic [CNT_W:0]   MIN_FULL = {MIN_CNT, 1'b0};
`else
  localparam int unsigned      RND_ADD  = 8;
  localparam int unsigned      SHIFT    = 4;
  localparam logic [CNT_W:0]   MIN_FULL = {1'b0, MIN_CNT};
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Synchronizer for the asynchronous serial line.
  logic rx_meta_q;
  logic rx_s_q;

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [DVSR_W-1:0]   pending_q, pending_d;
  logic                src_hw_q,  src_hw_d;
  logic [DVSR_W-1:0]   dvsr_q,    dvsr_d;
  logic                locked_q,  locked_d;
  logic                err_q,     err_d;
  logic                done_q,    done_d;

`ifdef AUTOBAUD_TWO_BIT_EN
  // Track the low-to-high transition inside the sync character.
  logic                rise_seen_q, rise_seen_d;
  logic [CNT_W-1:0]    rise_cnt_q,  rise_cnt_d;
  logic [CNT_W-1:0]    hi_len;
  logic                hi_over;
`endif

  // Datapath for the divisor calculation, evaluated from the held count.
  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W:0]      cnt_sum;
  logic [CNT_W:0]      quot;
  logic [CNT_W:0]      quot_m1;
  logic                too_short;
  logic                quot_zero;
  logic                too_big;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign cnt_sum   = {1'b0, cnt_q} + (CNT_W+1)'(RND_ADD);
  assign quot      = cnt_sum >> SHIFT;
  assign quot_m1   = quot - (CNT_W+1)'(1);
  assign too_short = ({1'b0, cnt_q} < MIN_FULL);
  assign quot_zero = (quot == '0);
  assign too_big   = |quot_m1[CNT_W:DVSR_W];

`ifdef AUTOBAUD_TWO_BIT_EN
  // High phase may last at most twice the low phase before it counts as stuck.
  assign hi_len  = cnt_inc - rise_cnt_q;
  assign hi_over = ({1'b0, hi_len} > {rise_cnt_q, 1'b0});
`endif

  // Two-flop synchronizer; resets to the idle-high line level.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would collapse the chain.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pending_q   <= '0;
      src_hw_q    <= 1'b0;
      dvsr_q      <= DEFAULT_DVSR;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef AUTOBAUD_TWO_BIT_EN
      rise_seen_q <= 1'b0;
      rise_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      src_hw_q    <= src_hw_d;
      dvsr_q      <= dvsr_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      done_q      <= done_d;
`ifdef AUTOBAUD_TWO_BIT_EN
      rise_seen_q <= rise_seen_d;
      rise_cnt_q  <= rise_cnt_d;
`endif
    end
  end

  // Next-state and register update logic for the measurement FSM.
  always_comb begin
    // NOTE: every signal gets its hold value first so no branch can leave
    // one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    pending_d   = pending_q;
    src_hw_d    = src_hw_q;
    dvsr_d      = dvsr_q;
    locked_d    = locked_q;
    err_d       = err_q;
    done_d      = 1'b0;
`ifdef AUTOBAUD_TWO_BIT_EN
    rise_seen_d = rise_seen_q;
    rise_cnt_d  = rise_cnt_q;
`endif

    if (wr_en_i) begin
      // A software write wins over everything: abort any measurement and
      // queue the new divisor for the next tick. start is ignored.
      pending_d = wr_dvsr_i;
      src_hw_d  = 1'b0;
      err_d     = 1'b0;
      locked_d  = 1'b0;
      state_d   = S_APPLY;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_d    = 1'b0;
            locked_d = 1'b0;
            cnt_d    = '0;
            state_d  = S_WAIT_IDLE;
          end
        end

        // Never start timing in the middle of a low period.
        S_WAIT_IDLE: begin
          if (rx_s_q) state_d = S_WAIT_FALL;
        end

        S_WAIT_FALL: begin
          if (!rx_s_q) begin
            cnt_d       = CNT_W'(1);
`ifdef AUTOBAUD_TWO_BIT_EN
            rise_seen_d = 1'b0;
            rise_cnt_d  = '0;
`endif
            state_d     = S_MEASURE;
          end
        end

        S_MEASURE: begin
`ifdef AUTOBAUD_TWO_BIT_EN
          if (rise_seen_q && !rx_s_q) begin
            state_d = S_CALC;
          end else if (cnt_inc == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (rx_s_q && rise_seen_q && hi_over) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (rx_s_q && !rise_seen_q) begin
              rise_seen_d = 1'b1;
              rise_cnt_d  = cnt_q;
            end
          end
`else
          if (rx_s_q) begin
            state_d = S_CALC;
          end else if (cnt_inc == CNT_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
`endif
        end

        // Round to nearest bit period and range-check the divisor.
        S_CALC: begin
          if (too_short || quot_zero || too_big) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            pending_d = quot_m1[DVSR_W-1:0];
            src_hw_d  = 1'b1;
            state_d   = S_APPLY;
          end
        end

        // Commit only on a tick so the generator period is never cut short.
        S_APPLY: begin
          if (tick_i) begin
            dvsr_d   = pending_q;
            done_d   = 1'b1;
            locked_d = src_hw_q;
            state_d  = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dvsr_o   = dvsr_q;
  assign busy_o   = (state_q != S_IDLE);
  assign locked_o = locked_q;
  assign err_o    = err_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: directed software writes,
// abort and reset cases plus randomized sync-character widths checked
// against an arithmetic model of the baud measurement.
`timescale 1ns/1ps

module tb_uart_autobaud_ctrl;

  logic        clk_i     = 1'b0;
  logic        reset_ni  = 1'b0;
  logic        rx_i      = 1'b1;
  logic        tick_i    = 1'b0;
  logic        wr_en_i   = 1'b0;
  logic [10:0] wr_dvsr_i = '0;
  logic        start_i   = 1'b0;
  logic [10:0] dvsr_o;
  logic        busy_o;
  logic        locked_o;
  logic        err_o;
  logic        done_o;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int tick_div = 0;
  int exp_dvsr = 17;

  uart_autobaud_ctrl dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .rx_i      (rx_i),
    .tick_i    (tick_i),
    .wr_en_i   (wr_en_i),
    .wr_dvsr_i (wr_dvsr_i),
    .start_i   (start_i),
    .dvsr_o    (dvsr_o),
    .busy_o    (busy_o),
    .locked_o  (locked_o),
    .err_o     (err_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Free-running baud tick, one pulse every 18 clocks (dvsr = 17).
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      tick_div = (tick_div == 17) ? 0 : tick_div + 1;
      tick_i   = (tick_div == 17);
    end
  end

  // Count done pulses.
  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outcome of a sync character whose low (and, in two-bit mode,
  // high) phase lasts w clocks.
  function automatic void model(input int w, output bit e, output int d);
    int tot;
    int q;
    int minw;
`ifdef AUTOBAUD_TWO_BIT_EN
    tot  = 2 * w;
    minw = 64;
    q    = (tot + 16) / 32;
`else
    tot  = w;
    minw = 32;
    q    = (tot + 8) / 16;
`endif
    e = (tot >= 65535) || (tot < minw) || (q == 0) || (q - 1 > 2047);
    d = q - 1;
  endfunction

  task automatic pulse_start();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    @(negedge clk_i);
    for (int i = 0; i < budget && busy_o; i++) @(negedge clk_i);
    check(tag, busy_o, 0);
  endtask

  task automatic measure(input string tag, input int w);
    bit e;
    int d;
    int done_before;
    model(w, e, d);
    done_before = done_cnt;
    pulse_start();
    repeat (3) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (w) @(posedge clk_i);
    #1 rx_i = 1'b1;
`ifdef AUTOBAUD_TWO_BIT_EN
    if (w < 60000) begin
      repeat (w) @(posedge clk_i);
      #1 rx_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rx_i = 1'b1;
    end
`endif
    wait_idle({tag, "_busy"}, 200);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    if (!e) exp_dvsr = d;
    check({tag, "_err"},    err_o,    e);
    check({tag, "_locked"}, locked_o, !e);
    check({tag, "_dvsr"},   dvsr_o,   exp_dvsr);
    check({tag, "_done"},   done_cnt - done_before, e ? 0 : 1);
  endtask

  initial begin
    bit fired;
    int k_fired;

    // Reset and idle.
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_dvsr",   dvsr_o,   17);
    check("rst_busy",   busy_o,   0);
    check("rst_locked", locked_o, 0);
    check("rst_err",    err_o,    0);
    check("rst_done",   done_cnt, 0);

    // Software write: commit exactly on the edge that samples the next tick.
    @(posedge clk_i); #1 wr_en_i = 1'b1; wr_dvsr_i = 11'd214;
    @(posedge clk_i); #1 wr_en_i = 1'b0;
    fired   = 1'b0;
    k_fired = -10;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      check("wr_dvsr_cycle", dvsr_o, fired ? 214 : 17);
      check("wr_done_cycle", done_o, (fired && k == k_fired + 1) ? 1 : 0);
      if (!fired && tick_i) begin
        fired   = 1'b1;
        k_fired = k;
      end
    end
    check("wr_busy",   busy_o,   0);
    check("wr_locked", locked_o, 0);
    exp_dvsr = 214;

    // Directed measurements and boundaries.
    measure("m115200", 286);
    measure("m9600",   3438);
    measure("glitch",  10);
    measure("min_m1",  31);
    measure("min",     32);

    // Randomized widths.
    for (int r = 0; r < 6; r++) begin
      measure("rand", int'($urandom_range(40, 1200)));
    end

    // Stuck-low line.
    measure("stuck", 65540);

    // Software write aborts a running measurement.
    pulse_start();
    repeat (3) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (100) @(posedge clk_i);
    #1 wr_en_i = 1'b1; wr_dvsr_i = 11'd50;
    @(posedge clk_i); #1 wr_en_i = 1'b0;
    @(negedge clk_i);
    check("abort_err",    err_o,    0);
    check("abort_locked", locked_o, 0);
    wait_idle("abort_busy", 100);
    #1 rx_i = 1'b1;
    exp_dvsr = 50;
    check("abort_dvsr", dvsr_o, exp_dvsr);
    check("abort_err2", err_o,  0);

    // Asynchronous reset in the middle of a measurement.
    pulse_start();
    repeat (3) @(posedge clk_i);
    #1 rx_i = 1'b0;
    repeat (100) @(posedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    check("arst_dvsr",   dvsr_o,   17);
    check("arst_busy",   busy_o,   0);
    check("arst_locked", locked_o, 0);
    rx_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 reset_ni = 1'b1;
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("post_rst_dvsr", dvsr_o, 17);
    check("post_rst_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
- Configuration controller for the UART baud generator: owns the 11-bit divisor driving baud_gen's dvsr input (tick = 16x oversample, dvsr = f_clk/(16*baud) - 1).
- Divisor is set either by a direct register write or by measuring the start-bit width of an incoming sync character (0x55 'U') on rx.
- All divisor changes are committed only on a tick pulse, so baud_gen never sees a mid-period change.

Parameters:
- DVSR_W, 11, divisor width (matches baud_gen).
- CNT_W, 16, measurement counter width.
- DEFAULT_DVSR, 11'd17, reset divisor (115200 baud at 33 MHz).
- MIN_CNT, 16'd32, shortest legal start-bit width in clk cycles; shorter is a glitch.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial line, idle high, asynchronous.
- tick  in  1  baud_gen tick, one clk wide.
- wr_en  in  1  load wr_dvsr (1-cycle strobe).
- wr_dvsr  in  DVSR_W  software divisor.
- start  in  1  arm autobaud measurement (1-cycle strobe).
- dvsr  out  DVSR_W  divisor to baud_gen.
- busy  out  1  high in any state other than IDLE.
- locked  out  1  divisor came from a successful measurement.
- err  out  1  sticky, last measurement failed; cleared by start or wr_en.
- done  out  1  1-cycle pulse when a new dvsr is committed.

Behaviour:
- rx passes through a 2-FF synchronizer (rx_s). Both edges see equal delay, so the width is unaffected.
- Reset (reset=0): state IDLE; dvsr=DEFAULT_DVSR; busy=0, locked=0, err=0, done=0; counter=0; pending=0.
- FSM states IDLE, WAIT_IDLE, WAIT_FALL, MEASURE, CALC, APPLY.
- IDLE:
  - start -> WAIT_IDLE; clear err and locked.
  - wr_en -> pending=wr_dvsr, src=sw, -> APPLY.
- WAIT_IDLE: wait for rx_s=1 so a measurement never starts mid-low; then -> WAIT_FALL.
- WAIT_FALL: rx_s=0 -> MEASURE with cnt=1.
- MEASURE:
  - Each cycle rx_s=0: cnt++.
  - rx_s=1 -> CALC.
  - cnt reaching all-ones -> err=1 -> IDLE (timeout/stuck line).
- CALC (1 cycle):
  - cnt<MIN_CNT -> err=1 -> IDLE.
  - Otherwise q=(cnt+8)>>4, computed in CNT_W+1 bits.
  - q=0 or q-1 > 2^DVSR_W-1 -> err=1 -> IDLE.
  - Otherwise pending=q-1, src=hw -> APPLY.
- APPLY: on first cycle with tick=1:
  - dvsr<=pending; done=1 next cycle.
  - locked<=(src==hw); -> IDLE.
  - Commit latency: at most dvsr_old+1 clks after entry.
- wr_en in any non-IDLE state aborts the operation:
  - pending=wr_dvsr -> APPLY; err=0; locked=0.
  - wr_en has priority over start in the same cycle; start is ignored.
- start while busy is ignored.
- tick and APPLY entry in the same cycle: commit waits for the next tick, since tick is sampled only in APPLY.
- Reset mid-operation aborts immediately, and dvsr returns to DEFAULT_DVSR.

Optional Feature:
- Macro AUTOBAUD_TWO_BIT_EN.
- Defined:
  - MEASURE continues through the start bit and bit0 of 0x55 (low then high). It ends on the next falling edge of rx_s.
  - A rising edge counts as part of the run, not as an end.
  - q=(cnt+16)>>5 for 2-bit averaging, halving quantisation error.
  - MIN_CNT check uses 2*MIN_CNT.
  - rx_s staying high for more than 2*(cnt at rise) cycles -> err=1 -> IDLE.
- Undefined: single start-bit measurement as above.

Test Plan:
- Reset, then idle 20 cycles -> dvsr=17, busy=0, locked=0, err=0, no done pulse.
- wr_en with wr_dvsr=214, baud_gen running dvsr=17 -> dvsr changes to 214 exactly on the cycle after the next tick; done pulses once; locked=0.
- start, then rx low for 286 clks (115200 @33 MHz) then high -> dvsr=17, locked=1, err=0. With AUTOBAUD_TWO_BIT_EN, 572-clk low/high pattern -> dvsr=17.
- start, then rx low for 3438 clks (9600 baud) -> dvsr=214, locked=1.
- start, then 10-clk low glitch -> err=1, dvsr unchanged, locked=0. start, then rx held low 65535 clks -> err=1, busy=0.
- start, then rx low; wr_en wr_dvsr=50 during MEASURE -> measurement aborted, dvsr=50 at next tick, err=0, locked=0. Assert reset mid-MEASURE -> dvsr=17 immediately.
